// File: rtl/execute_stage_pkg.sv
// Shared types and the combinational ALU function for the execute stage.
package execute_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_SLL  = 5'd5,
    OP_SRL  = 5'd6,
    OP_SRA  = 5'd7,
    OP_SLT  = 5'd8,
    OP_SLTU = 5'd9,
    OP_MUL  = 5'd10
  } alu_op_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } ex_state_t;

  // Single-cycle ops only; MUL and unlisted encodings yield 0 here.
  function automatic logic [XLEN-1:0] alu_compute(input logic [4:0]      op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    res = '0;
    case (alu_op_t'(op))
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLL:  res = a << b[4:0];
      OP_SRL:  res = a >> b[4:0];
      OP_SRA:  res = $unsigned($signed(a) >>> b[4:0]);
      OP_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/execute_stage_seq_multiplier.sv
// Iterative unsigned shift-add multiplier, one partial product per clock, low XLEN bits.
module seq_multiplier
  import execute_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_product
);

  logic            r_busy;
  logic [4:0]      r_cnt;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] w_step;

  // o_product already includes the current step, so the final edge can consume it.
  assign w_step    = r_mplier[0] ? r_mcand : '0;
  assign o_product = r_acc + w_step;
  assign o_busy    = r_busy;
  assign o_done    = r_busy & (r_cnt == 5'd31);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start && !r_busy) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= o_product;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus a 32-step iterative multiply that stalls upstream.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [4:0]      alu_control,
  input  logic            alu_src,
  input  logic            mem_write,
  input  logic            reg_write,
  input  logic [1:0]      mem_to_reg,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] RD1,
  input  logic [XLEN-1:0] RD2,
  input  logic [XLEN-1:0] signImm,
  input  logic [XLEN-1:0] pc_count,
  output logic            stall,
  output logic            valid_new,
  output logic [XLEN-1:0] alu_result_new,
  output logic [XLEN-1:0] write_data_new,
  output logic [XLEN-1:0] pc_count_new,
  output logic [4:0]      rd_addr_new,
  output logic [1:0]      mem_to_reg_new,
  output logic            mem_write_new,
  output logic            reg_write_new,
  output logic            zero_new
);

  ex_state_t       r_state;
  logic            r_lat_mw;
  logic            r_lat_rw;
  logic [1:0]      r_lat_mtr;
  logic [4:0]      r_lat_rd;
  logic [XLEN-1:0] r_lat_wd;
  logic [XLEN-1:0] r_lat_pc;

  logic            w_is_mul;
  logic            w_accept_mul;
  logic            w_mul_busy;
  logic            w_mul_done;
  logic [XLEN-1:0] w_opb;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_product;

  assign w_opb        = alu_src ? signImm : RD2;
  assign w_is_mul     = (alu_control == OP_MUL);
  assign w_alu        = alu_compute(alu_control, RD1, w_opb);
  assign w_accept_mul = ~rst & ~flush & (r_state == ST_IDLE) & in_valid & w_is_mul;

  // Stall drops on the final multiply cycle so upstream advances in step with the result.
  assign stall = w_accept_mul |
                 (~rst & ~flush & (r_state == ST_MUL_BUSY) & w_mul_busy & ~w_mul_done);

  seq_multiplier u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_accept_mul),
    .i_abort   (flush),
    .i_a       (RD1),
    .i_b       (w_opb),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_lat_mw       <= 1'b0;
      r_lat_rw       <= 1'b0;
      r_lat_mtr      <= '0;
      r_lat_rd       <= '0;
      r_lat_wd       <= '0;
      r_lat_pc       <= '0;
      valid_new      <= 1'b0;
      alu_result_new <= '0;
      write_data_new <= '0;
      pc_count_new   <= '0;
      rd_addr_new    <= '0;
      mem_to_reg_new <= '0;
      mem_write_new  <= 1'b0;
      reg_write_new  <= 1'b0;
      zero_new       <= 1'b0;
    end else if (flush) begin
      r_state       <= ST_IDLE;
      valid_new     <= 1'b0;
      mem_write_new <= 1'b0;
      reg_write_new <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && w_is_mul) begin
            r_state       <= ST_MUL_BUSY;
            r_lat_mw      <= mem_write;
            r_lat_rw      <= reg_write;
            r_lat_mtr     <= mem_to_reg;
            r_lat_rd      <= rd_addr;
            r_lat_wd      <= RD2;
            r_lat_pc      <= pc_count;
            valid_new     <= 1'b0;
            mem_write_new <= 1'b0;
            reg_write_new <= 1'b0;
          end else if (in_valid) begin
            valid_new      <= 1'b1;
            alu_result_new <= w_alu;
            zero_new       <= (w_alu == '0);
            write_data_new <= RD2;
            pc_count_new   <= pc_count;
            rd_addr_new    <= rd_addr;
            mem_to_reg_new <= mem_to_reg;
            mem_write_new  <= mem_write;
            reg_write_new  <= reg_write;
          end else begin
            valid_new     <= 1'b0;
            mem_write_new <= 1'b0;
            reg_write_new <= 1'b0;
          end
        end
        ST_MUL_BUSY: begin
          if (w_mul_done) begin
            r_state        <= ST_IDLE;
            valid_new      <= 1'b1;
            alu_result_new <= w_product;
            zero_new       <= (w_product == '0);
            write_data_new <= r_lat_wd;
            pc_count_new   <= r_lat_pc;
            rd_addr_new    <= r_lat_rd;
            mem_to_reg_new <= r_lat_mtr;
            mem_write_new  <= r_lat_mw;
            reg_write_new  <= r_lat_rw;
          end else begin
            valid_new     <= 1'b0;
            mem_write_new <= 1'b0;
            reg_write_new <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: vector table, directed multi-cycle sequences, random vs. model.
module tb_execute_stage;

  logic        clk, rst, flush, in_valid, alu_src, mem_write, reg_write;
  logic [4:0]  alu_control, rd_addr;
  logic [1:0]  mem_to_reg;
  logic [31:0] RD1, RD2, signImm, pc_count;
  logic        stall, valid_new, mem_write_new, reg_write_new, zero_new;
  logic [31:0] alu_result_new, write_data_new, pc_count_new;
  logic [4:0]  rd_addr_new;
  logic [1:0]  mem_to_reg_new;

  int ntests = 0;
  int nfail  = 0;

  // Model state: what the last valid output carried, and what the current drive carries.
  logic [31:0] last_res;
  logic [31:0] e_wd, e_pc;
  logic [4:0]  e_rd;
  logic [1:0]  e_mtr;
  logic        e_mw, e_rw;

  execute_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .alu_control(alu_control), .alu_src(alu_src),
    .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .rd_addr(rd_addr),
    .RD1(RD1), .RD2(RD2), .signImm(signImm), .pc_count(pc_count),
    .stall(stall), .valid_new(valid_new),
    .alu_result_new(alu_result_new), .write_data_new(write_data_new),
    .pc_count_new(pc_count_new), .rd_addr_new(rd_addr_new),
    .mem_to_reg_new(mem_to_reg_new), .mem_write_new(mem_write_new),
    .reg_write_new(reg_write_new), .zero_new(zero_new)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, imm;
    bit          src;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    int sh;
    sh = b % 32;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << sh;
      5'd6:  return a >> sh;
      5'd7:  return $unsigned($signed(a) >>> sh);
      5'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd9:  return (a < b) ? 32'd1 : 32'd0;
      5'd10: begin p = 64'(a) * 64'(b); return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input bit src,
                       input bit mw, input bit rw);
    in_valid = v; alu_control = op; RD1 = a; RD2 = b; signImm = imm; alu_src = src;
    mem_write = mw; reg_write = rw;
    mem_to_reg = 2'($urandom); rd_addr = 5'($urandom); pc_count = $urandom;
    e_wd = b; e_pc = pc_count; e_rd = rd_addr; e_mtr = mem_to_reg; e_mw = mw; e_rw = rw;
    #1;
  endtask

  task automatic chk_valid_out(input string nm, input logic [31:0] exp);
    chk({nm, ".valid"}, 32'(valid_new), 32'd1);
    chk({nm, ".result"}, alu_result_new, exp);
    chk({nm, ".zero"}, 32'(zero_new), 32'(exp == 32'd0));
    chk({nm, ".wdata"}, write_data_new, e_wd);
    chk({nm, ".pc"}, pc_count_new, e_pc);
    chk({nm, ".rd"}, 32'(rd_addr_new), 32'(e_rd));
    chk({nm, ".mtr"}, 32'(mem_to_reg_new), 32'(e_mtr));
    chk({nm, ".mw"}, 32'(mem_write_new), 32'(e_mw));
    chk({nm, ".rw"}, 32'(reg_write_new), 32'(e_rw));
    last_res = exp;
  endtask

  task automatic chk_bubble(input string nm);
    chk({nm, ".valid"}, 32'(valid_new), 32'd0);
    chk({nm, ".mw"}, 32'(mem_write_new), 32'd0);
    chk({nm, ".rw"}, 32'(reg_write_new), 32'd0);
    chk({nm, ".hold"}, alu_result_new, last_res);
  endtask

  // Drives a MUL and follows it; abort_at>0 flushes in that stall cycle (cycle n has cnt=n-1).
  task automatic do_mul(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input int abort_at, input bit mw, input bit rw);
    int n;
    drive(1'b1, 5'd10, a, b, $urandom, 1'b0, mw, rw);
    chk({nm, ".stall0"}, 32'(stall), 32'd1);
    n = 0;
    while (stall && n < 40) begin
      if (n == abort_at) begin
        flush = 1'b1; #1;
        chk({nm, ".stall_flush"}, 32'(stall), 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0; #1;
        chk_bubble({nm, ".flushed"});
        chk({nm, ".stall_after_flush"}, 32'(stall), 32'd0);
        return;
      end
      if (n > 0) begin
        chk({nm, ".busy_valid"}, 32'(valid_new), 32'd0);
        chk({nm, ".busy_mw"}, 32'(mem_write_new), 32'd0);
      end
      step();
      n++;
    end
    chk({nm, ".stall_cycles"}, n, 32);
    chk({nm, ".last_valid"}, 32'(valid_new), 32'd0);
    step();
    chk_valid_out({nm, ".out"}, ref_alu(5'd10, a, b));
  endtask

  vec_t tbl[12];

  initial begin
    int cnt;
    tbl[0]  = '{5'd0,  32'd5,          32'd7,          32'd0, 1'b0, 32'd12};
    tbl[1]  = '{5'd1,  32'd3,          32'd99,         32'd3, 1'b1, 32'd0};
    tbl[2]  = '{5'd7,  32'h8000_0000,  32'd4,          32'd0, 1'b0, 32'hF800_0000};
    tbl[3]  = '{5'd2,  32'hF0F0_FF00,  32'h0FF0_F0F0,  32'd0, 1'b0, 32'h00F0_F000};
    tbl[4]  = '{5'd3,  32'hF000_0001,  32'h0000_0F00,  32'd0, 1'b0, 32'hF000_0F01};
    tbl[5]  = '{5'd4,  32'hFFFF_0000,  32'h0F0F_0F0F,  32'd0, 1'b0, 32'hF0F0_0F0F};
    tbl[6]  = '{5'd5,  32'h0000_0003,  32'd0,          32'd33, 1'b1, 32'h0000_0006};
    tbl[7]  = '{5'd6,  32'h8000_0000,  32'd31,         32'd0, 1'b0, 32'h0000_0001};
    tbl[8]  = '{5'd8,  32'hFFFF_FFFF,  32'd1,          32'd0, 1'b0, 32'd1};
    tbl[9]  = '{5'd9,  32'hFFFF_FFFF,  32'd1,          32'd0, 1'b0, 32'd0};
    tbl[10] = '{5'd15, 32'd123,        32'd456,        32'd0, 1'b0, 32'd0};
    tbl[11] = '{5'd1,  32'd0,          32'd1,          32'd0, 1'b0, 32'hFFFF_FFFF};

    flush = 0; rst = 1; last_res = '0;
    drive(1'b1, 5'd10, 32'd7, 32'd9, 32'd0, 1'b0, 1'b1, 1'b1);
    chk("rst.stall", 32'(stall), 32'd0);
    step(); step();
    chk("rst.stall_held", 32'(stall), 32'd0);
    e_wd = '0; e_pc = '0; e_rd = '0; e_mtr = '0; e_mw = 1'b0; e_rw = 1'b0;
    chk("rst.valid", 32'(valid_new), 32'd0);
    chk("rst.result", alu_result_new, 32'd0);
    chk("rst.wdata", write_data_new, 32'd0);
    chk("rst.pc", pc_count_new, 32'd0);
    chk("rst.rd", 32'(rd_addr_new), 32'd0);
    chk("rst.zero", 32'(zero_new), 32'd0);
    in_valid = 0; rst = 0;
    step();

    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].src, 1'($urandom), 1'b1);
      chk($sformatf("vec%0d.stall", i), 32'(stall), 32'd0);
      step();
      chk_valid_out($sformatf("vec%0d", i), tbl[i].exp);
    end
    drive(1'b0, 5'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b1);
    step();
    chk_bubble("bubble");

    // Product spec example, then flush mid-multiply.
    do_mul("mul_ffff", 32'h0000_FFFF, 32'h0001_0001, -1, 1'b1, 1'b1);
    chk("mul_ffff.value", alu_result_new, 32'hFFFF_FFFF);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk_bubble("mul_ffff.one_shot");

    do_mul("mul_flush", 32'd1234, 32'd5678, 11, 1'b1, 1'b1);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin step(); if (valid_new) cnt++; end
    chk("mul_flush.no_product", cnt, 0);
    drive(1'b1, 5'd0, 32'd20, 32'd22, 32'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk_valid_out("mul_flush.idle_add", 32'd42);

    // Reset mid-multiply with nonzero outputs beforehand.
    drive(1'b1, 5'd10, 32'd77, 32'd3, 32'd0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) step();
    rst = 1'b1; #1;
    chk("rst_mul.stall", 32'(stall), 32'd0);
    step();
    chk("rst_mul.result", alu_result_new, 32'd0);
    chk("rst_mul.wdata", write_data_new, 32'd0);
    chk("rst_mul.pc", pc_count_new, 32'd0);
    chk("rst_mul.valid", 32'(valid_new), 32'd0);
    rst = 1'b0;
    drive(1'b1, 5'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk_valid_out("rst_mul.add", 32'd2);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin step(); if (valid_new) cnt++; end
    chk("rst_mul.no_product", cnt, 0);

    // Back-to-back MUL, ADD, bubble, all with mem_write requested.
    do_mul("b2b.mul", 32'hDEAD_BEEF, 32'h0000_1003, -1, 1'b1, 1'b0);
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b1, 1'b1);
    chk("b2b.add_stall", 32'(stall), 32'd0);
    step();
    chk_valid_out("b2b.add", 32'd1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    step();
    chk_bubble("b2b.bubble");

    // Random traffic against the reference model.
    for (int it = 0; it < 250; it++) begin
      int r;
      logic [4:0] op;
      logic [31:0] a, b, imm;
      bit src;
      r = int'($urandom_range(0, 99));
      a = $urandom; b = $urandom; imm = $urandom; src = 1'($urandom);
      if (r < 8) begin
        do_mul($sformatf("rnd%0d.mul", it), a, b,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : -1,
               1'($urandom), 1'($urandom));
      end else if (r < 20) begin
        drive(1'b0, 5'($urandom), a, b, imm, src, 1'($urandom), 1'($urandom));
        step();
        chk_bubble($sformatf("rnd%0d.bubble", it));
      end else if (r < 25) begin
        drive(1'b1, 5'($urandom), a, b, imm, src, 1'($urandom), 1'($urandom));
        flush = 1'b1; #1;
        chk($sformatf("rnd%0d.flush_stall", it), 32'(stall), 32'd0);
        step();
        flush = 1'b0;
        chk_bubble($sformatf("rnd%0d.flush", it));
      end else begin
        op = 5'($urandom_range(0, 15));
        if (op == 5'd10) op = 5'd11;
        drive(1'b1, op, a, b, imm, src, 1'($urandom), 1'($urandom));
        step();
        chk_valid_out($sformatf("rnd%0d.op%0d", it, op), ref_alu(op, a, src ? imm : b));
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Single clock clk, all state on its rising edge; rst synchronous, active-high.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 flush  in  1  kill the in-flight instruction (branch redirect).
REQ-005 in_valid  in  1  ID/EX slot holds a real instruction.
REQ-006 alu_control  in  5  operation code, encodings per REQ-030.
REQ-007 alu_src  in  1  1 = operand B is signImm, 0 = RD2.
REQ-008 mem_write / reg_write  in  1 each  memory-store and register-write enables.
REQ-009 mem_to_reg  in  2  writeback source select, passed through.
REQ-010 rd_addr  in  5  destination register, passed through.
REQ-011 RD1, RD2, signImm  in  32 each  operand A, store data / operand B, immediate.
REQ-012 pc_count  in  32  branch target from ID/EX, passed through.
REQ-013 stall  out  1  combinational; upstream holds ID/EX contents while high.
REQ-014 valid_new  out  1  EX/MEM slot holds a real instruction.
REQ-015 alu_result_new  out  32  operation result.
REQ-016 write_data_new  out  32  registered RD2 (store data).
REQ-017 pc_count_new, rd_addr_new, mem_to_reg_new  out  32/5/2  registered pass-throughs.
REQ-018 mem_write_new / reg_write_new  out  1 each  registered enables, forced 0 when valid_new=0.
REQ-019 zero_new  out  1  alu_result_new == 0.

Function
REQ-020 Operand B = alu_src ? signImm : RD2; all arithmetic modulo 2^32.
REQ-021 FSM states IDLE, MUL_BUSY; 5-bit iteration counter cnt.
REQ-022 IDLE, in_valid=1, non-MUL op: outputs updated at the next edge (latency 1), valid_new=1.
REQ-023 IDLE, in_valid=0: valid_new, mem_write_new and reg_write_new go 0 at the next edge; data outputs hold.
REQ-024 IDLE, in_valid=1, op MUL: the edge latches operands, cnt=0, ->MUL_BUSY; valid_new=0 at that edge.
REQ-025 MUL_BUSY: one shift-add step per edge, low 32 bits of the product, unsigned; valid_new=0 throughout.
REQ-026 MUL_BUSY with cnt==31: that edge writes the product and latched controls to outputs, valid_new=1, ->IDLE.
REQ-027 stall = ~flush & ((IDLE & in_valid & op==MUL) | (MUL_BUSY & cnt!=31)); upstream advances on the final multiply edge.
REQ-028 MUL latency: result visible 33 cycles after the acceptance cycle; exactly one output per accepted instruction.
REQ-029 flush=1 (priority below rst, above all else): next edge valid_new=0, enables 0, ->IDLE, multiply aborted, data outputs hold.
REQ-030 Encodings: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL.
REQ-031 Shifts use B[4:0]; SLT is signed and SLTU unsigned, both producing 0/1.
REQ-032 Unlisted opcodes produce result 0 and otherwise behave as valid single-cycle instructions.

Reset
REQ-033 rst=1 at an edge: every output 0, state IDLE, cnt 0, multiply registers 0; stall=0 while rst is high.
REQ-034 rst during MUL_BUSY aborts the multiply with no output produced.

Structure
REQ-035 Shared package holds the alu_op_t enum (REQ-030), the ex_state_t enum and the XLEN=32 constant.
REQ-036 Iterative multiplier is one sub-module, seq_multiplier (start, busy, done, product); the remaining logic is inline.

Verification
REQ-037 ADD: RD1=5, RD2=7, alu_src=0, reg_write=1 -> next cycle alu_result_new=12, valid_new=1, reg_write_new=1, zero_new=0.
REQ-038 SUB with immediate: RD1=3, signImm=3, alu_src=1 -> alu_result_new=0, zero_new=1; SRA of 0x80000000 by 4 -> 0xF8000000.
REQ-039 MUL: RD1=0xFFFF, RD2=0x10001 -> stall high for 32 cycles, valid_new=0 for 32 cycles, then alu_result_new=0xFFFFFFFF, valid_new=1 for exactly one cycle.
REQ-040 flush asserted at cnt=10 of a MUL -> next cycle valid_new=0, stall=0, state IDLE, no product ever emitted.
REQ-041 rst during MUL_BUSY, then ADD 1+1 -> all outputs 0 after reset; ADD result 2 one cycle after its acceptance.
REQ-042 Back-to-back MUL, ADD, bubble -> valid_new sequence matches REQ-022..028, with mem_write_new=0 on every invalid cycle.
